dab_gate_driver: RTL

- Downstream stage of the DAB modulator: converts the primary/secondary bridge voltage levels V1, V2 (signed 2-bit, -1/0/+1) into eight gate signals.
- Outputs are Sp[3:0] for the primary H-bridge and Ss[3:0] for the secondary H-bridge, with programmable deadtime per leg.
- Each bridge commutates only one leg per level change, alternating legs through the zero state.
- Output feeds the FPGA gate-driver pins directly.

---
 rtl/dab_pkg.sv | 23 ++
 rtl/dab_leg_deadtime.sv | 73 +++++++
 rtl/dab_gate_driver.sv | 112 +++++++++++
 3 files changed

// File: rtl/dab_pkg.sv
// Shared constants for the DAB gate driver: level codes, leg state encoding
// and gate bit positions within each bridge's 4-bit gate word.
package dab_pkg;

   localparam logic [1:0] V_POS  = 2'b01;
   localparam logic [1:0] V_ZERO = 2'b00;
   localparam logic [1:0] V_NEG  = 2'b11;
   localparam logic [1:0] V_ILL  = 2'b10;

   typedef enum logic [2:0] {
      OFF,
      LO_ON,
      DT_UP,
      HI_ON,
      DT_DN
   } leg_state_t;

   localparam int G_AH = 0;
   localparam int G_AL = 1;
   localparam int G_BH = 2;
   localparam int G_BL = 3;

endpackage

// File: rtl/dab_leg_deadtime.sv
// One half-bridge leg: five-state FSM with a dead-interval counter between
// low-side and high-side conduction. Gate outputs are registered.
module dab_leg_deadtime
   import dab_pkg::*;
#(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                en,
   input  logic                target,
   input  logic [DT_WIDTH-1:0] load,
   output logic                hi,
   output logic                lo
);

   localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);

   leg_state_t          state_reg, state_next;
   logic [DT_WIDTH-1:0] cnt_reg, cnt_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (!en) begin
         // Disable bypasses the clock enable so the gates drop promptly.
         state_next = OFF;
         cnt_next   = '0;
      end else if (ce) begin
         unique case (state_reg)
            OFF: begin
               cnt_next   = load;
               state_next = target ? DT_UP : DT_DN;
            end
            LO_ON: if (target) begin
               cnt_next   = load;
               state_next = DT_UP;
            end
            DT_UP: begin
               if (!target)          state_next = LO_ON;
               else if (cnt_reg <= ONE) state_next = HI_ON;
               else                  cnt_next   = cnt_reg - ONE;
            end
            HI_ON: if (!target) begin
               cnt_next   = load;
               state_next = DT_DN;
            end
            DT_DN: begin
               if (target)           state_next = HI_ON;
               else if (cnt_reg <= ONE) state_next = LO_ON;
               else                  cnt_next   = cnt_reg - ONE;
            end
            default: state_next = OFF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= OFF;
         cnt_reg   <= '0;
         hi        <= 1'b0;
         lo        <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         hi        <= (state_next == HI_ON);
         lo        <= (state_next == LO_ON);
      end
   end

endmodule

// File: rtl/dab_gate_driver.sv
// DAB gate driver: decodes V1/V2 levels into per-leg targets (one leg moves
// per level change) and drives four deadtime-protected legs.
module dab_gate_driver
   import dab_pkg::*;
#(
   parameter int DT_WIDTH = 8,
   parameter int DT_MIN   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                CE,
   input  logic                en,
   input  logic [DT_WIDTH-1:0] dt,
   input  logic signed [1:0]   V1,
   input  logic signed [1:0]   V2,
   output logic [3:0]          Sp,
   output logic [3:0]          Ss,
   output logic                err
);

   localparam logic [DT_WIDTH-1:0] DT_MIN_V = DT_WIDTH'(DT_MIN);

   logic [1:0]          v [2];
   logic [1:0]          tgt_a_reg, tgt_a_next;
   logic [1:0]          tgt_b_reg, tgt_b_next;
   logic [1:0]          lnz_reg, lnz_next;
   logic                err_reg, err_next;
   logic [3:0]          leg_tgt, leg_hi, leg_lo;
   logic [DT_WIDTH-1:0] load;

   assign v[0] = V1;
   assign v[1] = V2;
   assign load = (dt < DT_MIN_V) ? DT_MIN_V : dt;

   // Zero level parks both legs on the side used by the last nonzero level,
   // so each step through zero moves exactly one leg.
   always_comb begin
      tgt_a_next = tgt_a_reg;
      tgt_b_next = tgt_b_reg;
      lnz_next   = lnz_reg;
      err_next   = err_reg;
      if (CE) begin
         for (int b = 0; b < 2; b++) begin
            unique case (v[b])
               V_POS: begin
                  tgt_a_next[b] = 1'b1;
                  tgt_b_next[b] = 1'b0;
                  lnz_next[b]   = 1'b1;
               end
               V_NEG: begin
                  tgt_a_next[b] = 1'b0;
                  tgt_b_next[b] = 1'b1;
                  lnz_next[b]   = 1'b0;
               end
               V_ZERO: begin
                  tgt_a_next[b] = lnz_reg[b];
                  tgt_b_next[b] = lnz_reg[b];
               end
               V_ILL: if (en) err_next = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_a_reg <= '0;
         tgt_b_reg <= '0;
         lnz_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         tgt_a_reg <= tgt_a_next;
         tgt_b_reg <= tgt_b_next;
         lnz_reg   <= lnz_next;
         err_reg   <= err_next;
      end
   end

   assign err     = err_reg;
   assign leg_tgt = {tgt_b_reg[1], tgt_a_reg[1], tgt_b_reg[0], tgt_a_reg[0]};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_leg
         dab_leg_deadtime #(
            .DT_WIDTH (DT_WIDTH)
         ) u_leg (
            .clk    (clk),
            .rst    (rst),
            .ce     (CE),
            .en     (en),
            .target (leg_tgt[gi]),
            .load   (load),
            .hi     (leg_hi[gi]),
            .lo     (leg_lo[gi])
         );
      end
   endgenerate

   always_comb begin
      Sp       = '0;
      Ss       = '0;
      Sp[G_AH] = leg_hi[0];
      Sp[G_AL] = leg_lo[0];
      Sp[G_BH] = leg_hi[1];
      Sp[G_BL] = leg_lo[1];
      Ss[G_AH] = leg_hi[2];
      Ss[G_AL] = leg_lo[2];
      Ss[G_BH] = leg_hi[3];
      Ss[G_BL] = leg_lo[3];
   end

endmodule
